// File: rtl/wav_sequencer_pkg.sv
// Shared definitions for the wave playback path: sequencer FSM encoding,
// default sample-rate divider and the silence level driven to the PWM stage.
package wav_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WAIT    = 2'd3
    } wav_state_e;

    // 26 * 256 clocks per sample: 8 kHz from a 53.2 MHz clock
    localparam int DEFAULT_SAMPLE_DIV = 6656;

    localparam logic [7:0] SILENCE = 8'h00;

endpackage

// File: rtl/wav_sequencer_if.sv
// Sample ROM read port. The sequencer is the only master of this port;
// the ROM returns data exactly one cycle after a read.
interface wav_sequencer_if #(
    parameter int ADDR_W = 20
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_data
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_data
    );
endinterface

// File: rtl/wav_sequencer_prio_arbiter.sv
// Combinational fixed-priority encoder: the lowest set request index wins.
module prio_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    // Scan from the top down so the lowest requesting index is the last write
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wav_sequencer.sv
// Playback sequencer: latches clip triggers, arbitrates them by fixed
// priority and walks the sample ROM from start to end address of the granted
// clip at the sample rate, strobing each byte out to the PWM stage.
module wav_sequencer
    import wav_pkg::*;
#(
    parameter int NUM_CLIPS  = 4,
    parameter int ADDR_W     = 20,
    parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
    localparam int IDX_W     = $clog2(NUM_CLIPS),
    localparam int DIV_W     = $clog2(SAMPLE_DIV)
) (
    input  logic                        CLK,
    input  logic                        rst_n,
    input  logic [NUM_CLIPS-1:0]        trig,
    input  logic                        stop,
    input  logic [NUM_CLIPS*ADDR_W-1:0] clip_start,
    input  logic [NUM_CLIPS*ADDR_W-1:0] clip_end,
    wav_sequencer_if.master             mem,
    output logic [7:0]                  sample,
    output logic                        sample_stb,
    output logic                        playing,
    output logic [IDX_W-1:0]            active_clip,
    output logic                        clip_done
);

    wav_state_e           state;
    logic [NUM_CLIPS-1:0] pending;
    logic [ADDR_W-1:0]    ptr;
    logic [DIV_W-1:0]     div;

    logic [NUM_CLIPS-1:0] arb_req;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_idx;
    logic [NUM_CLIPS-1:0] grant_mask;
    logic [NUM_CLIPS-1:0] bypass_mask;
    logic [ADDR_W-1:0]    grant_start;
    logic [ADDR_W-1:0]    cur_end;
    logic                 div_last;
    logic                 in_capture;
    logic                 at_end;
    logic                 take_grant;

    assign in_capture  = (state == ST_CAPTURE);
    assign div_last    = (div == DIV_W'(SAMPLE_DIV - 1));
    assign cur_end     = clip_end[active_clip*ADDR_W +: ADDR_W];
    assign at_end      = (ptr >= cur_end);
    assign grant_start = clip_start[grant_idx*ADDR_W +: ADDR_W];

    // A trigger landing on the cycle a clip finishes must be able to win the
    // handover grant, so it bypasses the pending register during CAPTURE.
    assign arb_req = pending | (in_capture ? trig : '0);

    prio_arbiter #(
        .N     (NUM_CLIPS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req         (arb_req),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Grants happen from IDLE, at a finishing CAPTURE, and at the end of WAIT
    // when the winner is the active clip (restart) or outranks it (preempt).
    always_comb begin
        take_grant = 1'b0;
        if (!stop && grant_valid) begin
            unique case (state)
                ST_IDLE:    take_grant = 1'b1;
                ST_CAPTURE: take_grant = at_end;
                ST_WAIT:    take_grant = div_last && (grant_idx <= active_clip);
                default:    take_grant = 1'b0;
            endcase
        end
    end

    assign grant_mask  = take_grant ? (NUM_CLIPS'(1) << grant_idx) : '0;
    assign bypass_mask = in_capture ? grant_mask : '0;

    // Pending requests: set by trig, cleared on grant; stop wipes everything
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (stop) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~grant_mask) | (trig & ~bypass_mask);
        end
    end

    // Sample-rate divider; a grant from IDLE or WAIT restarts the sample period.
    // A handover at CAPTURE keeps the running phase so the seam between
    // back-to-back clips keeps the same strobe spacing.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if ((take_grant && !in_capture) || div_last) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Playback FSM with registered ROM port and PWM-side outputs
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            mem.mem_rd   <= 1'b0;
            mem.mem_addr <= '0;
            sample       <= SILENCE;
            sample_stb   <= 1'b0;
            playing      <= 1'b0;
            active_clip  <= '0;
            clip_done    <= 1'b0;
        end else if (stop) begin
            state      <= ST_IDLE;
            mem.mem_rd <= 1'b0;
            sample     <= SILENCE;
            sample_stb <= 1'b0;
            playing    <= 1'b0;
            clip_done  <= 1'b0;
        end else begin
            mem.mem_rd <= 1'b0;
            sample_stb <= 1'b0;
            clip_done  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    sample <= SILENCE;
                    if (take_grant) begin
                        state        <= ST_FETCH;
                        active_clip  <= grant_idx;
                        ptr          <= grant_start;
                        mem.mem_rd   <= 1'b1;
                        mem.mem_addr <= grant_start;
                        playing      <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    sample     <= mem.mem_data;
                    sample_stb <= 1'b1;
                    if (at_end) begin
                        clip_done <= 1'b1;
                        if (take_grant) begin
                            state       <= ST_WAIT;
                            active_clip <= grant_idx;
                            ptr         <= grant_start;
                        end else begin
                            state   <= ST_IDLE;
                            playing <= 1'b0;
                        end
                    end else begin
                        state <= ST_WAIT;
                        ptr   <= ptr + ADDR_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (div_last) begin
                        state      <= ST_FETCH;
                        mem.mem_rd <= 1'b1;
                        if (take_grant) begin
                            active_clip  <= grant_idx;
                            ptr          <= grant_start;
                            mem.mem_addr <= grant_start;
                        end else begin
                            mem.mem_addr <= ptr;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
